// File: rtl/memory_access_stage_pkg.sv
// Shared processor types for the memory access stage: access sizes, trap causes, result bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memory_access_stage_pkg;

    localparam int PKG_XLEN       = 32;
    localparam int PKG_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'd0,
        MEM_HALF    = 2'd1,
        MEM_WORD    = 2'd2,
        MEM_ILLEGAL = 2'd3   // behaves as a word access
    } MemAccessSize;

    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    // Everything the register-write stage sees for one instruction.
    typedef struct packed {
        logic                      valid;
        logic [PKG_XLEN-1:0]       pc;
        logic                      reg_write_enable;
        logic [PKG_REG_ADDR_W-1:0] dst_reg_addr;
        logic [PKG_XLEN-1:0]       dst_reg_value;
        logic                      trap_valid;
        logic [3:0]                trap_cause;
        logic [PKG_XLEN-1:0]       trap_value;
    } mem_result_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// Single-outstanding request/acknowledge data-memory port.
// Latency: n/a (signal bundle); master holds request fields stable until ack.
// Backpressure: the slave stretches a request simply by withholding mem_ack.
interface memory_access_stage_if #(
    parameter int XLEN = 32
) ();
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_byte_en;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_access_stage_load_store_aligner.sv
// Lane steering for a 32-bit data bus: store replication, byte enables, load extension, misalign check.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module load_store_aligner
    import memory_access_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  MemAccessSize    size,
    input  logic            is_unsigned,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_value,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Select the addressed lane, replicate store data across lanes, extend load data.
    always_comb begin
        load_byte  = rdata[{offset, 3'b000} +: 8];
        load_half  = offset[1] ? rdata[31:16] : rdata[15:0];
        wdata      = store_value;
        byte_en    = 4'b1111;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            MEM_BYTE: begin
                wdata     = {(XLEN/8){store_value[7:0]}};
                byte_en   = 4'b0001 << offset;
                load_data = is_unsigned ? {{(XLEN-8){1'b0}}, load_byte}
                                        : {{(XLEN-8){load_byte[7]}}, load_byte};
            end
            MEM_HALF: begin
                wdata      = {(XLEN/16){store_value[15:0]}};
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                load_data  = is_unsigned ? {{(XLEN-16){1'b0}}, load_half}
                                         : {{(XLEN-16){load_half[15]}}, load_half};
                misaligned = offset[0];
            end
            default: begin
                misaligned = (offset != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage: loads/stores over a one-outstanding req/ack port, traps, registered result.
// Latency: 1 cycle for non-memory ops and misaligned traps; ack cycle + 1 for memory ops.
// Backpressure: stall is high for the whole WAIT state; inputs are ignored while stalled.
// Optional build macro MEMORY_ACCESS_TIMEOUT_EN adds an ack watchdog raising access-fault traps.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int XLEN           = PKG_XLEN,
    parameter int REG_ADDR_W     = PKG_REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [XLEN-1:0]       in_addr,
    input  logic [XLEN-1:0]       in_store_value,
    input  logic                  in_reg_write_enable,
    input  logic [REG_ADDR_W-1:0] in_dst_reg_addr,
    input  logic [XLEN-1:0]       in_dst_reg_value,
    input  logic                  in_trap_valid,
    input  logic [3:0]            in_trap_cause,
    input  logic [XLEN-1:0]       in_trap_value,
    output logic                  stall,
    memory_access_stage_if.master mem,
    output logic                  out_valid,
    output logic [XLEN-1:0]       out_pc,
    output logic                  out_reg_write_enable,
    output logic [REG_ADDR_W-1:0] out_dst_reg_addr,
    output logic [XLEN-1:0]       out_dst_reg_value,
    output logic                  out_trap_valid,
    output logic [3:0]            out_trap_cause,
    output logic [XLEN-1:0]       out_trap_value
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // A zero-cycle watchdog has no meaning; this empty block flags such a setting in the hierarchy.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_must_be_positive
    end

    logic [0:0]            state;
    logic                  waiting;
    logic                  killed;      // flushed while the bus access is still in flight

    // Request latched at the IDLE->WAIT transition, held stable for the bus.
    logic [XLEN-1:0]       req_pc;
    logic                  req_is_load;
    MemAccessSize          req_size;
    logic                  req_unsigned;
    logic [XLEN-1:0]       req_addr;
    logic [XLEN-1:0]       req_wdata;
    logic [3:0]            req_byte_en;
    logic [REG_ADDR_W-1:0] req_rd;
    logic                  req_rwe;

    mem_result_t           result_q;

    MemAccessSize          al_size;
    logic                  al_unsigned;
    logic [1:0]            al_offset;
    logic [XLEN-1:0]       al_wdata;
    logic [3:0]            al_byte_en;
    logic [XLEN-1:0]       al_load_data;
    logic                  al_misaligned;
    logic                  is_mem_op;
    logic                  timeout_hit;

    assign waiting   = (state == S_WAIT);
    assign stall     = waiting;
    assign is_mem_op = in_load | in_store;

    // The aligner formats the incoming op in IDLE and the latched load's return data in WAIT.
    assign al_size     = waiting ? req_size     : MemAccessSize'(in_size);
    assign al_unsigned = waiting ? req_unsigned : in_unsigned;
    assign al_offset   = waiting ? req_addr[1:0] : in_addr[1:0];

    load_store_aligner #(.XLEN(XLEN)) u_aligner (
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .offset      (al_offset),
        .store_value (in_store_value),
        .rdata       (mem.mem_rdata),
        .wdata       (al_wdata),
        .byte_en     (al_byte_en),
        .load_data   (al_load_data),
        .misaligned  (al_misaligned)
    );

    assign mem.mem_req     = waiting;
    assign mem.mem_we      = waiting & ~req_is_load;
    assign mem.mem_addr    = {req_addr[XLEN-1:2], 2'b00};
    assign mem.mem_wdata   = req_wdata;
    assign mem.mem_byte_en = waiting ? req_byte_en : 4'b0000;

`ifdef MEMORY_ACCESS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;

    // Count cycles spent waiting for ack; cleared whenever the stage is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Stage FSM: accept from execute in IDLE, hold the bus in WAIT, register one result per op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            killed       <= 1'b0;
            req_pc       <= '0;
            req_is_load  <= 1'b0;
            req_size     <= MEM_BYTE;
            req_unsigned <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_byte_en  <= '0;
            req_rd       <= '0;
            req_rwe      <= 1'b0;
            result_q     <= '0;
        end else begin
            result_q.valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        if (in_trap_valid || !is_mem_op) begin
                            result_q.valid            <= 1'b1;
                            result_q.pc               <= in_pc;
                            result_q.reg_write_enable <= in_reg_write_enable & ~in_store;
                            result_q.dst_reg_addr     <= in_dst_reg_addr;
                            result_q.dst_reg_value    <= in_dst_reg_value;
                            result_q.trap_valid       <= in_trap_valid;
                            result_q.trap_cause       <= in_trap_cause;
                            result_q.trap_value       <= in_trap_value;
                        end else if (al_misaligned) begin
                            result_q.valid            <= 1'b1;
                            result_q.pc               <= in_pc;
                            result_q.reg_write_enable <= 1'b0;
                            result_q.dst_reg_addr     <= in_dst_reg_addr;
                            result_q.dst_reg_value    <= in_dst_reg_value;
                            result_q.trap_valid       <= 1'b1;
                            result_q.trap_cause       <= in_load ? CAUSE_LOAD_MISALIGNED
                                                                 : CAUSE_STORE_MISALIGNED;
                            result_q.trap_value       <= in_addr;
                        end else begin
                            state        <= S_WAIT;
                            killed       <= 1'b0;
                            req_pc       <= in_pc;
                            req_is_load  <= in_load;
                            req_size     <= MemAccessSize'(in_size);
                            req_unsigned <= in_unsigned;
                            req_addr     <= in_addr;
                            req_wdata    <= al_wdata;
                            req_byte_en  <= al_byte_en;
                            req_rd       <= in_dst_reg_addr;
                            req_rwe      <= in_reg_write_enable & in_load;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        killed <= 1'b1;
                    end
                    if (mem.mem_ack) begin
                        state <= S_IDLE;
                        if (!(killed || flush)) begin
                            result_q.valid            <= 1'b1;
                            result_q.pc               <= req_pc;
                            result_q.reg_write_enable <= req_rwe;
                            result_q.dst_reg_addr     <= req_rd;
                            result_q.dst_reg_value    <= al_load_data;
                            result_q.trap_valid       <= 1'b0;
                            result_q.trap_cause       <= '0;
                            result_q.trap_value       <= '0;
                        end
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                        if (!(killed || flush)) begin
                            result_q.valid            <= 1'b1;
                            result_q.pc               <= req_pc;
                            result_q.reg_write_enable <= 1'b0;
                            result_q.dst_reg_addr     <= req_rd;
                            result_q.trap_valid       <= 1'b1;
                            result_q.trap_cause       <= req_is_load ? CAUSE_LOAD_FAULT
                                                                     : CAUSE_STORE_FAULT;
                            result_q.trap_value       <= req_addr;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_valid            = result_q.valid;
    assign out_pc               = result_q.pc;
    assign out_reg_write_enable = result_q.reg_write_enable;
    assign out_dst_reg_addr     = result_q.dst_reg_addr;
    assign out_dst_reg_value    = result_q.dst_reg_value;
    assign out_trap_valid       = result_q.trap_valid;
    assign out_trap_cause       = result_q.trap_cause;
    assign out_trap_value       = result_q.trap_value;
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with hand-computed expectations.
// Inputs are driven and outputs sampled 1ns after each rising clock edge.
// The memory side is played directly by the bench through the interface.
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        in_load;
    logic        in_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [31:0] in_addr;
    logic [31:0] in_store_value;
    logic        in_reg_write_enable;
    logic [4:0]  in_dst_reg_addr;
    logic [31:0] in_dst_reg_value;
    logic        in_trap_valid;
    logic [3:0]  in_trap_cause;
    logic [31:0] in_trap_value;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic        out_reg_write_enable;
    logic [4:0]  out_dst_reg_addr;
    logic [31:0] out_dst_reg_value;
    logic        out_trap_valid;
    logic [3:0]  out_trap_cause;
    logic [31:0] out_trap_value;

    int n_checks = 0;
    int n_errors = 0;

    memory_access_stage_if #(.XLEN(32)) mem_bus ();

    memory_access_stage #(.XLEN(32), .REG_ADDR_W(5), .TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .in_valid             (in_valid),
        .in_pc                (in_pc),
        .in_load              (in_load),
        .in_store             (in_store),
        .in_size              (in_size),
        .in_unsigned          (in_unsigned),
        .in_addr              (in_addr),
        .in_store_value       (in_store_value),
        .in_reg_write_enable  (in_reg_write_enable),
        .in_dst_reg_addr      (in_dst_reg_addr),
        .in_dst_reg_value     (in_dst_reg_value),
        .in_trap_valid        (in_trap_valid),
        .in_trap_cause        (in_trap_cause),
        .in_trap_value        (in_trap_value),
        .stall                (stall),
        .mem                  (mem_bus),
        .out_valid            (out_valid),
        .out_pc               (out_pc),
        .out_reg_write_enable (out_reg_write_enable),
        .out_dst_reg_addr     (out_dst_reg_addr),
        .out_dst_reg_value    (out_dst_reg_value),
        .out_trap_valid       (out_trap_valid),
        .out_trap_cause       (out_trap_cause),
        .out_trap_value       (out_trap_value)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid            = 1'b0;
        in_pc               = '0;
        in_load             = 1'b0;
        in_store            = 1'b0;
        in_size             = 2'd0;
        in_unsigned         = 1'b0;
        in_addr             = '0;
        in_store_value      = '0;
        in_reg_write_enable = 1'b0;
        in_dst_reg_addr     = '0;
        in_dst_reg_value    = '0;
        in_trap_valid       = 1'b0;
        in_trap_cause       = '0;
        in_trap_value       = '0;
    endtask

    // Present one memory op from the execute stage.
    task automatic issue_mem(input logic [31:0] pc, input logic ld, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] sval,
                             input logic [4:0] rd);
        clear_inputs();
        in_valid            = 1'b1;
        in_pc               = pc;
        in_load             = ld;
        in_store            = ~ld;
        in_size             = size;
        in_unsigned         = uns;
        in_addr             = addr;
        in_store_value      = sval;
        in_reg_write_enable = 1'b1;
        in_dst_reg_addr     = rd;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        clear_inputs();
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
        check_eq("rst_byte_en", {28'd0, mem_bus.mem_byte_en}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_value", out_dst_reg_value, 32'd0);
        step();
        rst = 1'b0;
        step();

        // ALU op passes straight through in one cycle.
        clear_inputs();
        in_valid = 1'b1; in_pc = 32'h100; in_reg_write_enable = 1'b1;
        in_dst_reg_addr = 5'd3; in_dst_reg_value = 32'h1234;
        step();
        clear_inputs();
        check_eq("alu_valid", {31'd0, out_valid}, 32'd1);
        check_eq("alu_value", out_dst_reg_value, 32'h1234);
        check_eq("alu_rd", {27'd0, out_dst_reg_addr}, 32'd3);
        check_eq("alu_pc", out_pc, 32'h100);
        check_eq("alu_no_req", {31'd0, mem_bus.mem_req}, 32'd0);
        step();
        check_eq("alu_pulse", {31'd0, out_valid}, 32'd0);

        // lb 0x1003 signed, ack on the third WAIT cycle.
        issue_mem(32'h104, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h0, 5'd5);
        step();
        clear_inputs();
        check_eq("lb_req", {31'd0, mem_bus.mem_req}, 32'd1);
        check_eq("lb_addr", mem_bus.mem_addr, 32'h1000);
        check_eq("lb_we", {31'd0, mem_bus.mem_we}, 32'd0);
        check_eq("lb_stall1", {31'd0, stall}, 32'd1);
        step();
        check_eq("lb_stall2", {31'd0, stall}, 32'd1);
        step();
        check_eq("lb_stall3", {31'd0, stall}, 32'd1);
        check_eq("lb_no_out", {31'd0, out_valid}, 32'd0);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h80FFFFFF;
        step();
        mem_bus.mem_ack = 1'b0;
        check_eq("lb_stall_end", {31'd0, stall}, 32'd0);
        check_eq("lb_req_end", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("lb_valid", {31'd0, out_valid}, 32'd1);
        check_eq("lb_value", out_dst_reg_value, 32'hFFFFFF80);
        check_eq("lb_rd", {27'd0, out_dst_reg_addr}, 32'd5);
        check_eq("lb_rwe", {31'd0, out_reg_write_enable}, 32'd1);

        // lhu 0x4002: upper half, zero-extended.
        issue_mem(32'h108, 1'b1, 2'd1, 1'b1, 32'h4002, 32'h0, 5'd6);
        step();
        clear_inputs();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h80017FFF;
        step();
        mem_bus.mem_ack = 1'b0;
        check_eq("lhu_value", out_dst_reg_value, 32'h00008001);
        check_eq("lhu_valid", {31'd0, out_valid}, 32'd1);

        // sh 0x2002: upper lanes, rd write suppressed.
        issue_mem(32'h10C, 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 5'd7);
        step();
        clear_inputs();
        check_eq("sh_addr", mem_bus.mem_addr, 32'h2000);
        check_eq("sh_wdata", mem_bus.mem_wdata, 32'hABCDABCD);
        check_eq("sh_byte_en", {28'd0, mem_bus.mem_byte_en}, 32'hC);
        check_eq("sh_we", {31'd0, mem_bus.mem_we}, 32'd1);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        check_eq("sh_valid", {31'd0, out_valid}, 32'd1);
        check_eq("sh_rwe", {31'd0, out_reg_write_enable}, 32'd0);
        check_eq("sh_trap", {31'd0, out_trap_valid}, 32'd0);

        // sb 0x5001: replicated byte, lane 1.
        issue_mem(32'h110, 1'b0, 2'd0, 1'b0, 32'h5001, 32'h12345677, 5'd0);
        step();
        clear_inputs();
        check_eq("sb_wdata", mem_bus.mem_wdata, 32'h77777777);
        check_eq("sb_byte_en", {28'd0, mem_bus.mem_byte_en}, 32'h2);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;

        // lw 0x3001: misaligned, no bus request.
        issue_mem(32'h114, 1'b1, 2'd2, 1'b0, 32'h3001, 32'h0, 5'd8);
        #1;
        check_eq("lw_mis_req_pre", {31'd0, mem_bus.mem_req}, 32'd0);
        step();
        clear_inputs();
        check_eq("lw_mis_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("lw_mis_stall", {31'd0, stall}, 32'd0);
        check_eq("lw_mis_valid", {31'd0, out_valid}, 32'd1);
        check_eq("lw_mis_trap", {31'd0, out_trap_valid}, 32'd1);
        check_eq("lw_mis_cause", {28'd0, out_trap_cause}, 32'd4);
        check_eq("lw_mis_tval", out_trap_value, 32'h3001);
        check_eq("lw_mis_rwe", {31'd0, out_reg_write_enable}, 32'd0);

        // sh 0x6001: misaligned store.
        issue_mem(32'h118, 1'b0, 2'd1, 1'b0, 32'h6001, 32'h0, 5'd0);
        step();
        clear_inputs();
        check_eq("sh_mis_cause", {28'd0, out_trap_cause}, 32'd6);
        check_eq("sh_mis_tval", out_trap_value, 32'h6001);

        // Upstream trap on a load: copied, no bus access.
        issue_mem(32'h11C, 1'b1, 2'd2, 1'b0, 32'h7000, 32'h0, 5'd9);
        in_trap_valid = 1'b1; in_trap_cause = 4'd2; in_trap_value = 32'hDEAD;
        step();
        clear_inputs();
        check_eq("uptrap_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("uptrap_valid", {31'd0, out_valid}, 32'd1);
        check_eq("uptrap_cause", {28'd0, out_trap_cause}, 32'd2);
        check_eq("uptrap_tval", out_trap_value, 32'hDEAD);

        // Flush in IDLE drops the input.
        clear_inputs();
        in_valid = 1'b1; in_dst_reg_value = 32'h55; flush = 1'b1;
        step();
        clear_inputs(); flush = 1'b0;
        check_eq("flush_idle_valid", {31'd0, out_valid}, 32'd0);

        // Flush during WAIT: bus completes, result discarded.
        issue_mem(32'h120, 1'b1, 2'd2, 1'b0, 32'h7000, 32'h0, 5'd10);
        step();
        clear_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_wait_req", {31'd0, mem_bus.mem_req}, 32'd1);
        step();
        check_eq("flush_wait_req2", {31'd0, mem_bus.mem_req}, 32'd1);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h11112222;
        step();
        mem_bus.mem_ack = 1'b0;
        check_eq("flush_wait_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_wait_idle", {31'd0, mem_bus.mem_req}, 32'd0);

        // Flush coincident with ack: still discarded.
        issue_mem(32'h124, 1'b1, 2'd2, 1'b0, 32'h7004, 32'h0, 5'd11);
        step();
        clear_inputs();
        flush = 1'b1; mem_bus.mem_ack = 1'b1;
        step();
        flush = 1'b0; mem_bus.mem_ack = 1'b0;
        check_eq("flush_ack_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_ack_stall", {31'd0, stall}, 32'd0);

        // Reset in WAIT abandons the access immediately.
        issue_mem(32'h128, 1'b1, 2'd2, 1'b0, 32'h7008, 32'h0, 5'd12);
        step();
        clear_inputs();
        check_eq("rstwait_req_before", {31'd0, mem_bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rstwait_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("rstwait_stall", {31'd0, stall}, 32'd0);
        step();
        rst = 1'b0;
        step();

`ifdef MEMORY_ACCESS_TIMEOUT_EN
        // sw with no ack: four WAIT cycles then a store access fault.
        issue_mem(32'h12C, 1'b0, 2'd2, 1'b0, 32'h8000, 32'hCAFE, 5'd0);
        step();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            check_eq("to_req_held", {31'd0, mem_bus.mem_req}, 32'd1);
            step();
        end
        check_eq("to_req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("to_valid", {31'd0, out_valid}, 32'd1);
        check_eq("to_cause", {28'd0, out_trap_cause}, 32'd7);
        check_eq("to_tval", out_trap_value, 32'h8000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage between the execute stage and the register-write stage.
- Performs loads and stores over a single-outstanding request/acknowledge data-memory port.
- Detects misaligned accesses and formats load data with sign or zero extension.
- Presents one registered result per instruction, including trap information, to the register-write stage. Stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, data/address width.
- REG_ADDR_W, 5, register index width.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  kill the instruction held or in flight in this stage
- in_valid  in  1  execute-stage instruction valid
- in_pc  in  XLEN  instruction PC
- in_load  in  1  op is a load
- in_store  in  1  op is a store
- in_size  in  2  access size: 0 byte, 1 half, 2 word (3 illegal, treated as word)
- in_unsigned  in  1  zero-extend load data
- in_addr  in  XLEN  effective address
- in_store_value  in  XLEN  store data, right-aligned
- in_reg_write_enable  in  1  op writes rd
- in_dst_reg_addr  in  REG_ADDR_W  rd
- in_dst_reg_value  in  XLEN  ALU result, for non-load ops
- in_trap_valid / in_trap_cause / in_trap_value  in  1/4/XLEN  upstream trap
- stall  out  1  upstream must hold its inputs
- mem_req  out  1  request valid
- mem_we  out  1  write
- mem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- mem_wdata  out  XLEN  lane-shifted store data
- mem_byte_en  out  4  lane enables
- mem_ack  in  1  request complete; rdata valid for loads
- mem_rdata  in  XLEN  read word
- out_valid, out_pc, out_reg_write_enable, out_dst_reg_addr, out_dst_reg_value, out_trap_valid, out_trap_cause, out_trap_value  out  (as inputs)  registered result to the register-write stage

Behaviour:
- Reset: all out_* = 0, mem_req = 0, mem_we = 0, mem_byte_en = 0, stall = 0, FSM = IDLE. Reset asserted mid-WAIT abandons the access.
- FSM states: IDLE, WAIT.
- IDLE, in_valid and not flush:
  - Upstream trap, or no memory op: result registered next cycle. Latency 1. out_dst_reg_value = in_dst_reg_value; trap fields are copied.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0): no bus request. Output next cycle with out_trap_valid=1, cause 4 (load) or 6 (store), value=in_addr, out_reg_write_enable=0.
  - Aligned load/store: latch the request, assert mem_req next cycle, go to WAIT.
- WAIT:
  - mem_req held with stable fields; stall=1.
  - On mem_ack: register the result and go to IDLE. out_valid=1 the following cycle.
  - Ack in the same cycle as req entry is impossible; ack is sampled only in WAIT.
- stall = (state==WAIT), combinational.
- Load formatting: select the lane by addr[1:0]. Byte/half results are sign-extended unless in_unsigned.
- Store formatting:
  - byte: wdata = {4{b}}, byte_en = 1<<addr[1:0]
  - half: wdata = {2{h}}, byte_en = 0011 or 1100
  - word: byte_en = 1111
- out_valid pulses one cycle per instruction; out_* hold otherwise but are don't-care when out_valid=0.
- flush:
  - In IDLE: input dropped, out_valid=0 next cycle.
  - In WAIT: the bus transaction completes (mem_req held until ack), result discarded, out_valid stays 0.
- flush and mem_ack in the same cycle: result discarded.
- A store's out_reg_write_enable is forced to 0.

Optional Feature:
- Macro: MEMORY_ACCESS_TIMEOUT_EN.
- Defined: an 8-bit-min counter runs in WAIT. After TIMEOUT_CYCLES cycles without ack, the stage drops mem_req and returns to IDLE. It produces out_trap_valid=1, cause 5 (load) or 7 (store), value=address.
- Undefined: WAIT lasts indefinitely; no counter is instantiated.

Decomposition:
- Shared package (existing processor types package):
  - MemAccessSize enum
  - trap cause constants (misaligned/access-fault load/store)
  - result-bundle struct
- One sub-module: load_store_aligner. Purely combinational; holds lane shifting, byte-enable generation, load extension and the misalign check.

Test Plan:
- ALU op: in_valid, rd=3, value 0x1234 → out_valid next cycle, value 0x1234, no mem_req.
- lb addr 0x1003, unsigned=0, rdata 0x80FFFFFF, ack after 3 cycles → stall 3 cycles, out_dst_reg_value 0xFFFFFF80.
- sh addr 0x2002, value 0xABCD → mem_addr 0x2000, wdata 0xABCDABCD, byte_en 1100, out_reg_write_enable 0.
- lw addr 0x3001 → no mem_req, out_trap_valid=1, cause 4, value 0x3001.
- flush during WAIT for lw → mem_req held until ack, out_valid remains 0; reset in WAIT → mem_req 0 immediately.
- With MEMORY_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack on sw → trap cause 7 after 4 cycles, FSM returns to IDLE.
